// File: rtl/chip8_keypad_pkg.sv
// Shared constants for the CHIP-8 hex keypad scanner.
// Maps physical matrix position (row, col) to the CHIP-8 key value.
package chip8_keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [3:0] key_t;

    localparam key_t KEYMAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hC},
        '{4'h4, 4'h5, 4'h6, 4'hD},
        '{4'h7, 4'h8, 4'h9, 4'hE},
        '{4'hA, 4'h0, 4'hB, 4'hF}
    };

    function automatic logic [NUM_ROWS-1:0] row_drive(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

endpackage

// File: rtl/chip8_sync2.sv
// Two-flop synchronizer with a synchronous reset value.
// Brings asynchronous inputs into the clk domain.
module chip8_sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= RESET_VAL;
            stable <= RESET_VAL;
        end else begin
            meta   <= d;
            stable <= meta;
        end
    end

    assign q = stable;

endmodule

// File: rtl/chip8_keypad_scanner.sv
// 4x4 keypad matrix scanner with column synchronization and
// whole-matrix debounce; publishes a CHIP-8 indexed key bitmap.
module chip8_keypad_scanner
    import chip8_keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [15:0] keys_raw,
    output logic        scan_done
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int MW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [DW-1:0] DIV_MAX   = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_SCANS - 1);

    logic [3:0]    col_sync;
    logic [DW-1:0] div;
    logic [1:0]    row;
    logic [15:0]   scan_buf;
    logic [15:0]   last_snap;
    logic [MW-1:0] match;

    logic          last_div;
    logic          done;
    logic [15:0]   row_bits;
    logic [15:0]   snap;
    logic [MW-1:0] match_next;

    chip8_sync2 #(
        .WIDTH     (NUM_COLS),
        .RESET_VAL (4'b1111)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col_in),
        .q     (col_sync)
    );

    // snap folds the current row's samples into the partial scan
    always_comb begin
        row_bits = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (!col_sync[c]) begin
                row_bits[KEYMAP[row][c]] = 1'b1;
            end
        end
        snap     = scan_buf | row_bits;
        last_div = (div == DIV_MAX);
        done     = last_div && (row == 2'd3);
        if (snap != last_snap) begin
            match_next = '0;
        end else if (match == MATCH_MAX) begin
            match_next = match;
        end else begin
            match_next = match + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div       <= '0;
            row       <= '0;
            row_out   <= 4'b1110;
            scan_buf  <= '0;
            last_snap <= '0;
            match     <= '0;
            keys_raw  <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= done;
            div       <= last_div ? '0 : div + 1'b1;
            if (last_div) begin
                row      <= row + 2'd1;
                row_out  <= row_drive(row + 2'd1);
                scan_buf <= (row == 2'd3) ? '0 : snap;
            end
            if (done) begin
                last_snap <= snap;
                match     <= match_next;
                if (match_next == MATCH_MAX) begin
                    keys_raw <= snap;
                end
            end
        end
    end

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// Self-checking bench: keypad matrix model, table vectors, hand
// sequences and random presses against a per-scan reference model.
module tb_chip8_keypad_scanner;

    localparam int SD   = 4;
    localparam int DB   = 2;
    localparam int SCAN = 4 * SD;
    localparam int HMAX = 16384;

    // key value at physical position r*4+c
    localparam logic [3:0] KEY_AT [16] = '{
        4'h1, 4'h2, 4'h3, 4'hC,
        4'h4, 4'h5, 4'h6, 4'hD,
        4'h7, 4'h8, 4'h9, 4'hE,
        4'hA, 4'h0, 4'hB, 4'hF
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] keys_raw;
    logic        scan_done;

    logic [15:0] pressed;
    logic [15:0] hist [HMAX];
    logic [15:0] exp_keys;
    logic [15:0] prev_snap;
    int          run;
    int          cyc;
    int          checks;
    int          errors;

    typedef struct {
        logic [15:0] keys;
        int          hold;
        logic [15:0] want;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    chip8_keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_in    (col_in),
        .row_out   (row_out),
        .keys_raw  (keys_raw),
        .scan_done (scan_done)
    );

    // passive matrix: a held key shorts its column to the driven-low row
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (row_out[r] == 1'b0 && pressed[KEY_AT[r*4+c]]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h",
                     name, cyc, act, want);
        end
    endtask

    // row r is seen by the sampler as the keys held SD-3 cycles into its period
    function automatic logic [15:0] snap_of(input int n);
        logic [15:0] s;
        s = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (hist[SCAN*n + SD*r + SD - 3][KEY_AT[r*4+c]]) begin
                    s[KEY_AT[r*4+c]] = 1'b1;
                end
            end
        end
        return s;
    endfunction

    task automatic step(input logic [15:0] k);
        logic [15:0] s;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= HMAX) begin
            $display("FAIL cycle_budget at cycle %0d: got %h, expected %h",
                     cyc, cyc, HMAX - 1);
            $fatal(1, "cycle budget exhausted");
        end
        if (cyc % SCAN == 0) begin
            s = snap_of(cyc / SCAN - 1);
            run = (s == prev_snap) ? run + 1 : 1;
            prev_snap = s;
            if (run >= DB) exp_keys = s;
        end
        chk("row_out", 16'(row_out), 16'(~(4'b0001 << ((cyc / SD) % 4)) & 4'hF));
        chk("scan_done", 16'(scan_done), 16'(cyc % SCAN == 0));
        chk("keys_raw", keys_raw, exp_keys);
        pressed = k;
        hist[cyc] = k;
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        repeat (n) step(k);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        chk("reset_row_out", 16'(row_out), 16'h000E);
        chk("reset_keys_raw", keys_raw, 16'h0000);
        chk("reset_scan_done", 16'(scan_done), 16'h0000);
        reset     = 1'b0;
        cyc       = 0;
        hist[0]   = pressed;
        run       = 1;
        prev_snap = '0;
        exp_keys  = '0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        pressed = '0;
        reset   = 1'b1;

        tbl[0] = '{16'h0000, 40, 16'h0000};
        tbl[1] = '{16'h0040, 50, 16'h0040};
        tbl[2] = '{16'h1001, 50, 16'h1001};
        tbl[3] = '{16'h0000, 50, 16'h0000};
        tbl[4] = '{16'h8000, 50, 16'h8000};
        tbl[5] = '{16'hFFFF, 50, 16'hFFFF};
        tbl[6] = '{16'h0002, 50, 16'h0002};
        tbl[7] = '{16'h0400, 50, 16'h0400};

        do_reset(3);

        // idle: row rotation and scan_done cadence
        hold(16'h0000, 64);

        for (int i = 0; i < 8; i++) begin
            hold(tbl[i].keys, tbl[i].hold);
            chk($sformatf("table_%0d", i), keys_raw, tbl[i].want);
        end

        hold(16'h0000, 50);
        chk("pre_bounce", keys_raw, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            step(((i / 5) % 2 == 1) ? 16'h0000 : 16'h0040);
            chk("bounce_clean", 16'(keys_raw == 16'h0000 || keys_raw == 16'h0040), 16'h0001);
        end
        for (int i = 0; i < 50; i++) begin
            step(16'h0040);
            chk("bounce_settle", 16'(keys_raw == 16'h0000 || keys_raw == 16'h0040), 16'h0001);
        end
        chk("bounce_final", keys_raw, 16'h0040);

        hold(16'h1001, 50);
        chk("combo_held", keys_raw, 16'h1001);
        for (int i = 0; i < 50; i++) begin
            step(16'h0000);
            chk("release_clean", 16'(keys_raw == 16'h0000 || keys_raw == 16'h1001), 16'h0001);
        end
        chk("release_final", keys_raw, 16'h0000);

        // reset in the middle of row 2 with key 6 held
        hold(16'h0040, 40);
        while (cyc % SCAN != 2*SD + 1) step(16'h0040);
        do_reset(1);
        hold(16'h0000, 40);
        chk("post_reset_idle", keys_raw, 16'h0000);

        for (int seg = 0; seg < 60; seg++) begin
            logic [15:0] k;
            case ($urandom_range(0, 3))
                0: k = 16'h0000;
                1: k = 16'h0001 << $urandom_range(0, 15);
                2: k = (16'h0001 << $urandom_range(0, 15)) |
                       (16'h0001 << $urandom_range(0, 15));
                default: k = 16'($urandom);
            endcase
            hold(k, $urandom_range(1, 40));
        end
        hold(16'h0000, 50);
        chk("random_final", keys_raw, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
